// File: rtl/mole_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mole_game_ctrl
// Description : Whack-a-mole round sequencer: IDLE/PLAY/OVER control, LFSR
//               mole spawning into a 3x3 grid, per-hole lifetimes, scoring.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_game_ctrl #(
  parameter int unsigned     SPAWN_CYCLES     = 50_000_000,
  parameter int unsigned     MOLE_LIFE_CYCLES = 100_000_000,
  parameter longint unsigned GAME_CYCLES      = 64'd3_000_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  input  logic       key_valid,
  output logic [8:0] mole_mask,
  output logic [7:0] score,
  output logic [7:0] miss,
  output logic [1:0] state,
  output logic       hit_pulse,
  output logic       game_over
);

  localparam int c_HOLES   = 9;
  localparam int c_GAME_W  = $clog2(GAME_CYCLES + 64'd1);
  localparam int c_SPAWN_W = $clog2(longint'(SPAWN_CYCLES) + 64'd1);
  localparam int c_LIFE_W  = $clog2(longint'(MOLE_LIFE_CYCLES) + 64'd1);

  localparam logic [c_GAME_W-1:0]  c_GAME_LOAD  = c_GAME_W'(GAME_CYCLES - 64'd1);
  localparam logic [c_SPAWN_W-1:0] c_SPAWN_LOAD = c_SPAWN_W'(longint'(SPAWN_CYCLES) - 64'd1);
  localparam logic [c_LIFE_W-1:0]  c_LIFE_LOAD  = c_LIFE_W'(longint'(MOLE_LIFE_CYCLES) - 64'd1);
  localparam logic [15:0]          c_LFSR_SEED  = 16'hACE1;
  localparam logic [7:0]           c_KEY_START  = 8'h29;
  localparam logic [7:0]           c_KEY_ABORT  = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [15:0]           r_lfsr;
  logic [8:0]            r_mask, w_mask_nxt;
  logic [7:0]            r_score, w_score_nxt;
  logic [7:0]            r_miss, w_miss_nxt;
  logic                  r_hit, w_hit_nxt;
  logic                  r_game_over;
  logic [c_GAME_W-1:0]   r_game, w_game_nxt;
  logic [c_SPAWN_W-1:0]  r_spawn, w_spawn_nxt;
  logic [c_LIFE_W-1:0]   r_life     [c_HOLES];
  logic [c_LIFE_W-1:0]   w_life_nxt [c_HOLES];

  logic                  w_key_start, w_key_abort;
  logic                  w_key_hole_vld;
  logic [3:0]            w_key_hole;
  logic [8:0]            w_hole_hit, w_hole_exp;
  logic                  w_any_hit, w_wrong;
  logic [3:0]            w_exp_cnt;
  logic [3:0]            w_cand;
  logic                  w_spawn_now;
  logic [8:0]            w_score_sum, w_miss_sum;
  logic                  w_start_play;

  assign w_key_start = key_valid && (key == c_KEY_START);
  assign w_key_abort = key_valid && (key == c_KEY_ABORT);

  always_comb begin
    w_key_hole_vld = key_valid;
    w_key_hole     = 4'd0;
    case (key)
      8'h6C:   w_key_hole = 4'd0;
      8'h75:   w_key_hole = 4'd1;
      8'h7D:   w_key_hole = 4'd2;
      8'h6B:   w_key_hole = 4'd3;
      8'h73:   w_key_hole = 4'd4;
      8'h74:   w_key_hole = 4'd5;
      8'h69:   w_key_hole = 4'd6;
      8'h72:   w_key_hole = 4'd7;
      8'h7A:   w_key_hole = 4'd8;
      default: w_key_hole_vld = 1'b0;
    endcase
  end

  // A hit on a hole whose life just ran out takes precedence over the expiry.
  for (genvar h = 0; h < c_HOLES; h++) begin : g_hole
    assign w_hole_hit[h] = r_mask[h] && w_key_hole_vld && (w_key_hole == 4'(h));
    assign w_hole_exp[h] = r_mask[h] && !w_hole_hit[h] && (r_life[h] == '0);
  end

  assign w_any_hit   = |w_hole_hit;
  assign w_wrong     = w_key_hole_vld && !r_mask[w_key_hole];
  assign w_cand      = (r_lfsr[3:0] >= 4'd9) ? (r_lfsr[3:0] - 4'd9) : r_lfsr[3:0];
  assign w_spawn_now = (r_spawn == '0);

  always_comb begin
    w_exp_cnt = 4'd0;
    for (int h = 0; h < c_HOLES; h++) begin
      w_exp_cnt = w_exp_cnt + {3'b000, w_hole_exp[h]};
    end
  end

  assign w_score_sum = {1'b0, r_score} + {8'b0, w_any_hit};
  assign w_miss_sum  = {1'b0, r_miss} + {5'b0, w_exp_cnt} + {8'b0, w_wrong};

  always_comb begin
    w_state_nxt  = r_state;
    w_mask_nxt   = r_mask;
    w_score_nxt  = r_score;
    w_miss_nxt   = r_miss;
    w_hit_nxt    = 1'b0;
    w_game_nxt   = r_game;
    w_spawn_nxt  = r_spawn;
    w_start_play = 1'b0;
    for (int h = 0; h < c_HOLES; h++) begin
      w_life_nxt[h] = r_life[h];
    end

    case (r_state)
      ST_PLAY: begin
        if (w_key_abort) begin
          w_state_nxt = ST_IDLE;
          w_mask_nxt  = '0;
        end else begin
          w_hit_nxt   = w_any_hit;
          w_score_nxt = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
          w_miss_nxt  = (w_miss_sum > 9'd255) ? 8'hFF : w_miss_sum[7:0];
          for (int h = 0; h < c_HOLES; h++) begin
            if (w_hole_hit[h] || w_hole_exp[h]) begin
              w_mask_nxt[h] = 1'b0;
            end else if (r_mask[h]) begin
              w_life_nxt[h] = r_life[h] - c_LIFE_W'(1);
            end
          end
          // Spawn tests the pre-cycle mask, so a hole vacated this cycle is not refilled.
          if (w_spawn_now) begin
            w_spawn_nxt = c_SPAWN_LOAD;
            if (!r_mask[w_cand]) begin
              w_mask_nxt[w_cand] = 1'b1;
              w_life_nxt[w_cand] = c_LIFE_LOAD;
            end
          end else begin
            w_spawn_nxt = r_spawn - c_SPAWN_W'(1);
          end
          if (r_game == '0) begin
            w_state_nxt = ST_OVER;
            w_mask_nxt  = '0;
          end else begin
            w_game_nxt = r_game - c_GAME_W'(1);
          end
        end
      end
      ST_OVER: begin
        w_mask_nxt = '0;
        if (w_key_start) begin
          w_start_play = 1'b1;
        end else if (w_key_abort) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_mask_nxt  = '0;
        if (w_key_start) begin
          w_start_play = 1'b1;
        end
      end
    endcase

    if (w_start_play) begin
      w_state_nxt = ST_PLAY;
      w_score_nxt = '0;
      w_miss_nxt  = '0;
      w_mask_nxt  = '0;
      w_game_nxt  = c_GAME_LOAD;
      w_spawn_nxt = c_SPAWN_LOAD;
      for (int h = 0; h < c_HOLES; h++) begin
        w_life_nxt[h] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lfsr      <= c_LFSR_SEED;
      r_mask      <= '0;
      r_score     <= '0;
      r_miss      <= '0;
      r_hit       <= 1'b0;
      r_game_over <= 1'b0;
      r_game      <= '0;
      r_spawn     <= '0;
      for (int h = 0; h < c_HOLES; h++) begin
        r_life[h] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      r_mask      <= w_mask_nxt;
      r_score     <= w_score_nxt;
      r_miss      <= w_miss_nxt;
      r_hit       <= w_hit_nxt;
      r_game_over <= (w_state_nxt == ST_OVER);
      r_game      <= w_game_nxt;
      r_spawn     <= w_spawn_nxt;
      for (int h = 0; h < c_HOLES; h++) begin
        r_life[h] <= w_life_nxt[h];
      end
    end
  end

  assign mole_mask = r_mask;
  assign score     = r_score;
  assign miss      = r_miss;
  assign state     = r_state;
  assign hit_pulse = r_hit;
  assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: doc/mole_game_ctrl.md
# mole_game_ctrl

Game sequencer for the whack-a-mole design. Consumes the one-cycle scancode events from the keyboard front end, runs the IDLE/PLAY/OVER state machine, spawns moles pseudo-randomly into a 3x3 grid, and retires each mole on a correct hit or on timeout. It keeps saturating hit and miss counters. Its outputs drive the display and score blocks.

## Interface
- SPAWN_CYCLES, default 50_000_000: clk cycles between spawn attempts.
- MOLE_LIFE_CYCLES, default 100_000_000: cycles a mole stays up if not hit.
- GAME_CYCLES, default 3_000_000_000: length of one round in cycles. Counter width is $clog2(GAME_CYCLES+1), 64-bit safe.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset: synchronous, active-high.
- key  in  8  scancode. Valid only while key_valid=1.
- key_valid  in  1  one-cycle pulse per new key press.
- mole_mask  out  9  bit i=1 means hole i is occupied. Holes are numbered row-major from the top-left.
- score  out  8  hit count, saturates at 255.
- miss  out  8  miss count (timeouts plus wrong keys), saturates at 255.
- state  out  2  0=IDLE, 1=PLAY, 2=OVER. Value 3 is never driven.
- hit_pulse  out  1  one-cycle pulse on each successful hit.
- game_over  out  1  high while state=OVER.

## Operation
- Reset values: all outputs 0, state=IDLE. Internal state on reset:
  - All counters cleared.
  - 16-bit LFSR seeded 16'hACE1.
  - The LFSR uses taps x^16+x^14+x^13+x^11+1 and advances every cycle in every state.
- Key map (numpad):
  - Holes 0..8 are 6C, 75, 7D, 6B, 73, 74, 69, 72, 7A.
  - START = 29 (space). ABORT = 76 (Esc).
  - All other scancodes are ignored.
- IDLE:
  - mole_mask=0; score and miss hold.
  - START moves to PLAY. On entry, score, miss, mole_mask and all per-hole life counters clear; game timer loads GAME_CYCLES-1; spawn timer loads SPAWN_CYCLES-1.
- PLAY:
  - The game timer decrements once per cycle. When it is 0, the next state is OVER.
  - The spawn timer decrements. When it is 0, it reloads and a spawn attempt is made:
    - Candidate hole h = lfsr[3:0], minus 9 if lfsr[3:0] >= 9.
    - If mole_mask[h]=0 (value at the start of the cycle), set the bit and load life[h]=MOLE_LIFE_CYCLES-1.
    - If the hole is occupied, the attempt is dropped and not retried.
  - Each occupied hole decrements its life counter. At 0 the bit clears and the hole counts as one expiry.
  - A key press mapped to hole h:
    - If the hole is occupied: clear the bit, score+1, pulse hit_pulse.
    - If the hole is empty: one wrong-key miss.
  - ABORT moves to IDLE with mole_mask cleared; score and miss hold.
  - START during PLAY is ignored.
- OVER:
  - mole_mask=0; score and miss hold.
  - START restarts PLAY with the same clears as from IDLE.
  - ABORT moves to IDLE.
- Counter arithmetic:
  - miss_next = min(255, miss + expiries_this_cycle + wrong_key), where expiries_this_cycle is 0..9.
  - score_next = min(255, score + hit).
- Simultaneous events:
  - Hit and expiry on the same hole in the same cycle: the hit wins. score+1, no miss.
  - Spawn to a hole being hit or expiring in the same cycle: the spawn is dropped, because it tests the pre-cycle mask.
  - Game timer reaching 0 in the same cycle as a hit: the hit is scored; the state becomes OVER next cycle with mask 0.
  - ABORT in the same cycle as a spawn or expiry: ABORT wins; no counter changes that cycle.
- rst mid-game returns everything to reset values on the next edge.

## Timing
- All outputs are registered.
- A key_valid event at edge N is visible on mole_mask, score, miss and state after edge N+1. hit_pulse is high for exactly the cycle following N+1.
- The first spawn attempt occurs SPAWN_CYCLES cycles after the PLAY entry edge.
- A spawned mole stays up for exactly MOLE_LIFE_CYCLES cycles.
- PLAY lasts exactly GAME_CYCLES cycles, then state=2.
- key_valid is never back-pressured. Every event is processed in the cycle it arrives, so no buffering is needed.

## Test plan
Bench parameters: SPAWN_CYCLES=16, MOLE_LIFE_CYCLES=40, GAME_CYCLES=1000.
- Reset, then space pulse. After 1 cycle: state=1, score=0, miss=0. The first mole appears 16 cycles later, in hole lfsr[3:0] mod-9 as sampled by a reference model.
- Press the mapped key of the occupied hole (e.g. hole 4, key 73). Next cycle: bit 4 cleared, score=1, hit_pulse high for 1 cycle. Then press 73 again. Next cycle: miss=1, score unchanged.
- Let a mole live untouched. Its bit clears exactly 40 cycles after it was set, and miss increments by 1. Two moles expiring in the same cycle give miss+2.
- Hit delivered in the same cycle the life counter reaches 0: score+1, miss unchanged. Force both counters to 254 and trigger events: both stop at 255.
- Run 1000 cycles: state=2, game_over=1, mask=0, score and miss hold. Then space: state=1 with counters cleared. Then Esc: state=0.
- Assert rst mid-PLAY with 3 moles up: next cycle all outputs are 0 and state=0. Keys other than the map, START and ABORT (e.g. 1C) cause no change in any state.
